rx_os_checker: RTL and testbench
================================

Name: rx_os_checker

Overview:
Per-lane receive ordered-set checker; one instance per lane, MAXLANES instances in the RX path. Counts consecutive received ordered sets that match what the current LTSSM substate expects. Its comparatorMet output is one bit of the countersComparators bus read by the master RX LTSSM controller. That controller drives this block's run enable (one bit of resetOsCheckers), substate and comparatorsCount.

Parameters:
CNT_WIDTH, 5, width of the consecutive-match counter and of comparatorsCount
PAD_SYMBOL, 8'hF7, byte value meaning PAD (K23.7) in the link/lane number fields

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous active-low reset
resetChecker  input  1  run enable (resetOsCheckers bit): 0 = hold cleared, 1 = check
substate  input  4  LTSSM substate code (0 detectQuiet .. 9 configurationIdle)
comparatorsCount  input  CNT_WIDTH  consecutive matches required
osValid  input  1  one-cycle pulse, one complete ordered set decoded this cycle
osType  input  3  0 other, 1 TS1, 2 TS2, 3 EIOS, 4 SKP, 5 IDLE
linkNum  input  8  link number field of TS
laneNum  input  8  lane number field of TS
comparatorMet  output  1  threshold reached (countersComparators bit)
consecutiveCount  output  CNT_WIDTH  current consecutive-match count
capturedLinkNum  output  8  link number of first OS in current run
capturedLaneNum  output  8  lane number of first OS in current run

Behaviour:
- Reset (async, reset=0): all outputs 0, state CLEARED.
- States: CLEARED, HUNT, COUNT, MET. All outputs registered.
- CLEARED: count=0, captures=0, comparatorMet=0.
  - resetChecker=1 -> HUNT next cycle.
  - resetChecker=0 in any state -> CLEARED next cycle, all outputs cleared. Synchronous; has priority over osValid.
- Substate change (substate != substate registered last cycle) while not CLEARED: count cleared, -> HUNT. Same priority as resetChecker=0.
- Expected-OS match rules, by substate:
  - 0,1: none.
  - 2: TS1 or TS2, link=PAD, lane=PAD.
  - 3: TS2, link=PAD, lane=PAD.
  - 4: TS1, link!=PAD, lane=PAD.
  - 5: TS1, link!=PAD, lane!=PAD.
  - 6,7,8: TS2, link!=PAD, lane!=PAD.
  - 9: IDLE.
  - 10-15: none.
- HUNT:
  - If comparatorsCount==0 -> MET next cycle, independent of osValid.
  - Else a matching osValid -> count=1, capture link/lane, -> COUNT (or MET if comparatorsCount==1).
- COUNT, on matching osValid:
  - Link/lane equal to captured (always equal for PAD or IDLE) -> count+1.
  - Otherwise -> count=1, recapture, stay COUNT.
  - Count reaching >= comparatorsCount -> MET.
- COUNT, on other osValid:
  - osType=SKP is ignored (does not break the run).
  - Any other non-matching osValid -> count=0, -> HUNT.
- Counter saturates at 2^CNT_WIDTH-1; no wrap.
- MET:
  - comparatorMet=1, sticky until resetChecker=0 or substate change.
  - Count keeps incrementing on further matches (saturating); mismatches do not clear comparatorMet.
- Latency: comparatorMet rises the cycle after the osValid that reaches the threshold.
- comparatorsCount is sampled every cycle. Lowering it to <= count while in COUNT -> MET next cycle.

Optional Feature:
Macro OS_CHECKER_ERRCNT_EN.
- Defined: adds output mismatchCount (8 bits).
  - Increments on each non-SKP, non-matching osValid while in HUNT, COUNT or MET.
  - Saturates at 255.
  - Cleared by reset, resetChecker=0 or substate change.
- Undefined: port and logic absent; all other behaviour identical.

Test Plan:
- Reset low mid-COUNT with count=5 -> next edge all outputs 0, state CLEARED; release, resetChecker=1 -> HUNT.
- substate=2, comparatorsCount=8, 8 TS1 link=lane=8'hF7 -> consecutiveCount steps 1..8; comparatorMet=1 the cycle after the 8th osValid.
- substate=5, comparatorsCount=2: TS1 (link 3, lane 0), then TS1 (link 4, lane 0) -> count 1 then 1 with capturedLinkNum=4; third TS1 (link 4, lane 0) -> count 2, comparatorMet=1.
- substate=3, comparatorsCount=8: 4 TS2, 1 SKP, 1 TS1 -> count 4, stays 4 after SKP, 0 after TS1 (HUNT); with OS_CHECKER_ERRCNT_EN, mismatchCount=1.
- substate=0, comparatorsCount=0, resetChecker 0->1 -> comparatorMet=1 two cycles after rise (HUNT then MET); resetChecker->0 -> comparatorMet=0 next cycle.
- In MET at substate=8, substate changes to 9 -> comparatorMet=0 and count=0 next cycle; 300 non-matching osValid with ERRCNT enabled -> mismatchCount saturates at 255.

Source files
------------

// File: rtl/rx_os_checker.sv
// Per-lane receive ordered-set checker: counts consecutive ordered sets matching the LTSSM substate.
// Optional mismatch counter output enabled with macro OS_CHECKER_ERRCNT_EN.
module rx_os_checker #(
  parameter int         CNT_WIDTH  = 5,
  parameter logic [7:0] PAD_SYMBOL = 8'hF7
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 resetChecker,
  input  logic [3:0]           substate,
  input  logic [CNT_WIDTH-1:0] comparatorsCount,
  input  logic                 osValid,
  input  logic [2:0]           osType,
  input  logic [7:0]           linkNum,
  input  logic [7:0]           laneNum,
  output logic                 comparatorMet,
  output logic [CNT_WIDTH-1:0] consecutiveCount,
  output logic [7:0]           capturedLinkNum,
  output logic [7:0]           capturedLaneNum
`ifdef OS_CHECKER_ERRCNT_EN
  ,
  output logic [7:0]           mismatchCount
`endif
);

  localparam logic [2:0] OS_TS1  = 3'd1;
  localparam logic [2:0] OS_TS2  = 3'd2;
  localparam logic [2:0] OS_SKP  = 3'd4;
  localparam logic [2:0] OS_IDLE = 3'd5;

  localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = {CNT_WIDTH{1'b1}};

  typedef enum logic [1:0] {
    ST_CLEARED = 2'd0,
    ST_HUNT    = 2'd1,
    ST_COUNT   = 2'd2,
    ST_MET     = 2'd3
  } state_t;

  state_t               state_r;
  state_t               state_s;
  logic [CNT_WIDTH-1:0] cnt_r;
  logic [CNT_WIDTH-1:0] cnt_s;
  logic [7:0]           cap_link_r;
  logic [7:0]           cap_link_s;
  logic [7:0]           cap_lane_r;
  logic [7:0]           cap_lane_s;
  logic [3:0]           substate_r;
  logic                 met_r;

  logic                 match_s;
  logic                 miss_s;
  logic                 same_s;
  logic                 sub_chg_s;
  logic [CNT_WIDTH-1:0] cnt_inc_s;
  logic [CNT_WIDTH-1:0] run_cnt_s;

`ifdef OS_CHECKER_ERRCNT_EN
  logic [7:0]           err_r;
  logic [7:0]           err_s;
`endif

  // Expected ordered set for a substate: type plus PAD / non-PAD link and lane fields.
  function automatic logic os_expected(input logic [3:0] sub, input logic [2:0] typ,
                                       input logic [7:0] link, input logic [7:0] lane);
    logic link_pad;
    logic lane_pad;
    logic ok;
    link_pad = (link == PAD_SYMBOL);
    lane_pad = (lane == PAD_SYMBOL);
    case (sub)
      4'd2:             ok = ((typ == OS_TS1) || (typ == OS_TS2)) && link_pad && lane_pad;
      4'd3:             ok = (typ == OS_TS2) && link_pad && lane_pad;
      4'd4:             ok = (typ == OS_TS1) && !link_pad && lane_pad;
      4'd5:             ok = (typ == OS_TS1) && !link_pad && !lane_pad;
      4'd6, 4'd7, 4'd8: ok = (typ == OS_TS2) && !link_pad && !lane_pad;
      4'd9:             ok = (typ == OS_IDLE);
      default:          ok = 1'b0;
    endcase
    return ok;
  endfunction

  assign match_s   = osValid && os_expected(substate, osType, linkNum, laneNum);
  assign miss_s    = osValid && !match_s && (osType != OS_SKP);
  // IDLE carries no link/lane numbers, so any IDLE continues the run.
  assign same_s    = (substate == 4'd9) ||
                     ((linkNum == cap_link_r) && (laneNum == cap_lane_r));
  assign sub_chg_s = (substate != substate_r);
  assign cnt_inc_s = (cnt_r == CNT_MAX) ? CNT_MAX : (cnt_r + CNT_ONE);
  assign run_cnt_s = same_s ? cnt_inc_s : CNT_ONE;

  // Next-state, run counter and capture logic.
  always_comb begin
    state_s    = state_r;
    cnt_s      = cnt_r;
    cap_link_s = cap_link_r;
    cap_lane_s = cap_lane_r;
`ifdef OS_CHECKER_ERRCNT_EN
    err_s      = err_r;
`endif
    if (!resetChecker) begin
      state_s    = ST_CLEARED;
      cnt_s      = CNT_ZERO;
      cap_link_s = 8'h00;
      cap_lane_s = 8'h00;
`ifdef OS_CHECKER_ERRCNT_EN
      err_s      = 8'h00;
`endif
    end else if ((state_r != ST_CLEARED) && sub_chg_s) begin
      state_s = ST_HUNT;
      cnt_s   = CNT_ZERO;
`ifdef OS_CHECKER_ERRCNT_EN
      err_s   = 8'h00;
`endif
    end else begin
`ifdef OS_CHECKER_ERRCNT_EN
      if ((state_r != ST_CLEARED) && miss_s && (err_r != 8'hFF)) begin
        err_s = err_r + 8'd1;
      end else begin
        err_s = err_r;
      end
`endif
      case (state_r)
        ST_CLEARED: begin
          state_s = ST_HUNT;
        end
        ST_HUNT: begin
          if (comparatorsCount == CNT_ZERO) begin
            state_s = ST_MET;
          end else if (match_s) begin
            cnt_s      = CNT_ONE;
            cap_link_s = linkNum;
            cap_lane_s = laneNum;
            state_s    = (comparatorsCount == CNT_ONE) ? ST_MET : ST_COUNT;
          end else begin
            state_s = ST_HUNT;
          end
        end
        ST_COUNT: begin
          if (match_s) begin
            cnt_s      = run_cnt_s;
            cap_link_s = same_s ? cap_link_r : linkNum;
            cap_lane_s = same_s ? cap_lane_r : laneNum;
            state_s    = (run_cnt_s >= comparatorsCount) ? ST_MET : ST_COUNT;
          end else if (miss_s) begin
            cnt_s   = CNT_ZERO;
            state_s = ST_HUNT;
          end else begin
            // SKP or idle cycle; threshold may have been lowered under a live run
            state_s = (cnt_r >= comparatorsCount) ? ST_MET : ST_COUNT;
          end
        end
        ST_MET: begin
          if (match_s) begin
            cnt_s      = run_cnt_s;
            cap_link_s = same_s ? cap_link_r : linkNum;
            cap_lane_s = same_s ? cap_lane_r : laneNum;
          end else begin
            cnt_s = cnt_r;
          end
          state_s = ST_MET;
        end
        default: begin
          state_s = ST_CLEARED;
          cnt_s   = CNT_ZERO;
        end
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r    <= ST_CLEARED;
      cnt_r      <= CNT_ZERO;
      cap_link_r <= 8'h00;
      cap_lane_r <= 8'h00;
      substate_r <= 4'd0;
      met_r      <= 1'b0;
    end else begin
      state_r    <= state_s;
      cnt_r      <= cnt_s;
      cap_link_r <= cap_link_s;
      cap_lane_r <= cap_lane_s;
      substate_r <= substate;
      met_r      <= (state_s == ST_MET);
    end
  end

`ifdef OS_CHECKER_ERRCNT_EN
  // Saturating mismatch counter register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_r <= 8'h00;
    end else begin
      err_r <= err_s;
    end
  end

  assign mismatchCount = err_r;
`endif

  assign comparatorMet    = met_r;
  assign consecutiveCount = cnt_r;
  assign capturedLinkNum  = cap_link_r;
  assign capturedLaneNum  = cap_lane_r;

endmodule

// File: tb/tb_rx_os_checker.sv
// Self-checking bench for rx_os_checker: directed vector table, hand sequences, and
// randomized stimulus against a rule-table reference model.
module tb_rx_os_checker;

  logic       clk = 1'b0;
  logic       reset;
  logic       rc;
  logic [3:0] sub;
  logic [4:0] cc;
  logic       v;
  logic [2:0] t;
  logic [7:0] link;
  logic [7:0] lane;
  logic       met;
  logic [4:0] cnt;
  logic [7:0] clink;
  logic [7:0] clane;
`ifdef OS_CHECKER_ERRCNT_EN
  logic [7:0] err;
`endif

  rx_os_checker dut (
    .clk              (clk),
    .reset            (reset),
    .resetChecker     (rc),
    .substate         (sub),
    .comparatorsCount (cc),
    .osValid          (v),
    .osType           (t),
    .linkNum          (link),
    .laneNum          (lane),
    .comparatorMet    (met),
    .consecutiveCount (cnt),
    .capturedLinkNum  (clink),
    .capturedLaneNum  (clane)
`ifdef OS_CHECKER_ERRCNT_EN
    ,
    .mismatchCount    (err)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, got, exp);
  endtask

  // ---------------- reference model ----------------
  int type_mask [16];
  int link_rule [16];   // 0 any, 1 must be PAD, 2 must not be PAD
  int lane_rule [16];
  bit m_active, m_met;
  int m_cnt, m_clink, m_clane, m_err, m_prev_sub;

  function automatic bit rule_ok(input int rule, input logic [7:0] f);
    if (rule == 1) return f == 8'hF7;
    if (rule == 2) return f != 8'hF7;
    return 1'b1;
  endfunction

  function automatic bit model_match();
    return v && type_mask[sub][t] && rule_ok(link_rule[sub], link) && rule_ok(lane_rule[sub], lane);
  endfunction

  task automatic model_advance();
    if (sub == 4'd9 || (int'(link) == m_clink && int'(lane) == m_clane)) begin
      m_cnt = (m_cnt + 1 > 31) ? 31 : m_cnt + 1;
    end else begin
      m_cnt = 1; m_clink = link; m_clane = lane;
    end
  endtask

  task automatic model_clear();
    m_active = 0; m_met = 0; m_cnt = 0; m_clink = 0; m_clane = 0; m_err = 0;
  endtask

  task automatic model_step();
    bit mt, miss;
    mt   = model_match();
    miss = v && !mt && (t != 3'd4);
    if (!reset) begin
      model_clear(); m_prev_sub = 0; return;
    end
    if (!rc) model_clear();
    else if (!m_active) m_active = 1;
    else if (int'(sub) != m_prev_sub) begin
      m_cnt = 0; m_met = 0; m_err = 0;
    end else begin
      if (miss && m_err < 255) m_err++;
      if (m_met) begin
        if (mt) model_advance();
      end else if (m_cnt == 0) begin
        if (cc == 0) m_met = 1;
        else if (mt) begin
          m_cnt = 1; m_clink = link; m_clane = lane;
          if (cc <= 1) m_met = 1;
        end
      end else begin
        if (mt) model_advance();
        else if (miss) m_cnt = 0;
        if (m_cnt > 0 && m_cnt >= int'(cc)) m_met = 1;
      end
    end
    m_prev_sub = sub;
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic drive(input logic r, input logic [3:0] s, input logic [4:0] c, input logic vv,
                       input logic [2:0] tt, input logic [7:0] lk, input logic [7:0] ln);
    rc = r; sub = s; cc = c; v = vv; t = tt; link = lk; lane = ln;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic       rc;
    logic [3:0] sub;
    logic [4:0] cc;
    logic       v;
    logic [2:0] t;
    logic [7:0] link;
    logic [7:0] lane;
    logic       met;
    logic [4:0] cnt;
    logic [7:0] clink;
    logic [7:0] err;
  } vec_t;
  vec_t vq[$];

  task automatic add(input logic r, input logic [3:0] s, input logic [4:0] c, input logic vv,
                     input logic [2:0] tt, input logic [7:0] lk, input logic [7:0] ln,
                     input logic em, input logic [4:0] ec, input logic [7:0] el, input logic [7:0] ee);
    vec_t x;
    x.rc = r; x.sub = s; x.cc = c; x.v = vv; x.t = tt; x.link = lk; x.lane = ln;
    x.met = em; x.cnt = ec; x.clink = el; x.err = ee;
    vq.push_back(x);
  endtask

  initial begin
    for (int s = 0; s < 16; s++) begin
      type_mask[s] = 0; link_rule[s] = 0; lane_rule[s] = 0;
    end
    type_mask[2] = 'b000110; link_rule[2] = 1; lane_rule[2] = 1;
    type_mask[3] = 'b000100; link_rule[3] = 1; lane_rule[3] = 1;
    type_mask[4] = 'b000010; link_rule[4] = 2; lane_rule[4] = 1;
    type_mask[5] = 'b000010; link_rule[5] = 2; lane_rule[5] = 2;
    for (int s = 6; s <= 8; s++) begin
      type_mask[s] = 'b000100; link_rule[s] = 2; lane_rule[s] = 2;
    end
    type_mask[9] = 'b100000;
    model_clear(); m_prev_sub = 0;

    // substate 2, threshold 8, PAD TS1 run
    add(1'b1, 4'd2, 5'd8, 1'b0, 3'd0, 8'h00, 8'h00, 1'b0, 5'd0, 8'h00, 8'd0);
    add(1'b1, 4'd2, 5'd8, 1'b0, 3'd0, 8'h00, 8'h00, 1'b0, 5'd0, 8'h00, 8'd0);
    for (int k = 1; k <= 8; k++)
      add(1'b1, 4'd2, 5'd8, 1'b1, 3'd1, 8'hF7, 8'hF7, (k == 8), 5'(k), 8'hF7, 8'd0);
    add(1'b1, 4'd2, 5'd8, 1'b0, 3'd0, 8'h00, 8'h00, 1'b1, 5'd8, 8'hF7, 8'd0);
    add(1'b0, 4'd2, 5'd8, 1'b0, 3'd0, 8'h00, 8'h00, 1'b0, 5'd0, 8'h00, 8'd0);
    // substate 5, threshold 2, link number changes mid-run
    add(1'b1, 4'd5, 5'd2, 1'b0, 3'd0, 8'h00, 8'h00, 1'b0, 5'd0, 8'h00, 8'd0);
    add(1'b1, 4'd5, 5'd2, 1'b1, 3'd1, 8'h03, 8'h00, 1'b0, 5'd1, 8'h03, 8'd0);
    add(1'b1, 4'd5, 5'd2, 1'b1, 3'd1, 8'h04, 8'h00, 1'b0, 5'd1, 8'h04, 8'd0);
    add(1'b1, 4'd5, 5'd2, 1'b1, 3'd1, 8'h04, 8'h00, 1'b1, 5'd2, 8'h04, 8'd0);
    add(1'b0, 4'd5, 5'd2, 1'b0, 3'd0, 8'h00, 8'h00, 1'b0, 5'd0, 8'h00, 8'd0);
    // substate 3: TS2 run, SKP ignored, TS1 breaks it
    add(1'b1, 4'd3, 5'd8, 1'b0, 3'd0, 8'h00, 8'h00, 1'b0, 5'd0, 8'h00, 8'd0);
    for (int k = 1; k <= 4; k++)
      add(1'b1, 4'd3, 5'd8, 1'b1, 3'd2, 8'hF7, 8'hF7, 1'b0, 5'(k), 8'hF7, 8'd0);
    add(1'b1, 4'd3, 5'd8, 1'b1, 3'd4, 8'hF7, 8'hF7, 1'b0, 5'd4, 8'hF7, 8'd0);
    add(1'b1, 4'd3, 5'd8, 1'b1, 3'd1, 8'hF7, 8'hF7, 1'b0, 5'd0, 8'hF7, 8'd1);
    add(1'b1, 4'd3, 5'd8, 1'b1, 3'd2, 8'h05, 8'h05, 1'b0, 5'd0, 8'hF7, 8'd2);
    // substate change to 9, IDLE run ignores link/lane values
    add(1'b1, 4'd9, 5'd2, 1'b0, 3'd0, 8'h00, 8'h00, 1'b0, 5'd0, 8'hF7, 8'd0);
    add(1'b1, 4'd9, 5'd2, 1'b1, 3'd5, 8'h01, 8'h01, 1'b0, 5'd1, 8'h01, 8'd0);
    add(1'b1, 4'd9, 5'd2, 1'b1, 3'd5, 8'h02, 8'h02, 1'b1, 5'd2, 8'h01, 8'd0);
    add(1'b1, 4'd9, 5'd2, 1'b1, 3'd1, 8'hF7, 8'hF7, 1'b1, 5'd2, 8'h01, 8'd1);
    add(1'b0, 4'd9, 5'd2, 1'b0, 3'd0, 8'h00, 8'h00, 1'b0, 5'd0, 8'h00, 8'd0);
  end

  // ---------------- test sequence ----------------
  initial begin
    reset = 1'b0;
    drive(1'b0, 4'd0, 5'd0, 1'b0, 3'd0, 8'h00, 8'h00);
    step(); step();
    check("reset_met", met, 0);
    check("reset_cnt", cnt, 0);
    check("reset_clink", clink, 0);
    check("reset_clane", clane, 0);
    reset = 1'b1;
    step();

    for (int i = 0; i < vq.size(); i++) begin
      drive(vq[i].rc, vq[i].sub, vq[i].cc, vq[i].v, vq[i].t, vq[i].link, vq[i].lane);
      step();
      check($sformatf("vec%0d_met", i), met, vq[i].met);
      check($sformatf("vec%0d_cnt", i), cnt, vq[i].cnt);
      check($sformatf("vec%0d_clink", i), clink, vq[i].clink);
`ifdef OS_CHECKER_ERRCNT_EN
      check($sformatf("vec%0d_err", i), err, vq[i].err);
`endif
    end

    // comparatorsCount = 0: HUNT then MET without any ordered set
    drive(1'b0, 4'd0, 5'd0, 1'b0, 3'd0, 8'h00, 8'h00);
    step();
    rc = 1'b1;
    step(); check("cc0_hunt_met", met, 0);
    step(); check("cc0_met", met, 1); check("cc0_cnt", cnt, 0);
    rc = 1'b0;
    step(); check("cc0_clear_met", met, 0);

    // MET at substate 8, then change to 9, then saturate mismatch counter
    drive(1'b1, 4'd8, 5'd1, 1'b0, 3'd0, 8'h00, 8'h00);
    step();
    drive(1'b1, 4'd8, 5'd1, 1'b1, 3'd2, 8'h02, 8'h02);
    step(); check("s8_met", met, 1); check("s8_cnt", cnt, 1); check("s8_clink", clink, 2);
    drive(1'b1, 4'd9, 5'd1, 1'b0, 3'd0, 8'h00, 8'h00);
    step(); check("s9_chg_met", met, 0); check("s9_chg_cnt", cnt, 0);
    drive(1'b1, 4'd9, 5'd1, 1'b1, 3'd1, 8'hF7, 8'hF7);
    for (int k = 0; k < 300; k++) step();
    v = 1'b0;
    check("s9_miss_met", met, 0); check("s9_miss_cnt", cnt, 0);
`ifdef OS_CHECKER_ERRCNT_EN
    check("err_saturate", err, 255);
`endif

    // asynchronous reset in the middle of a run at count 5
    drive(1'b0, 4'd6, 5'd20, 1'b0, 3'd0, 8'h00, 8'h00);
    step();
    rc = 1'b1;
    step();
    drive(1'b1, 4'd6, 5'd20, 1'b1, 3'd2, 8'h01, 8'h01);
    for (int k = 0; k < 5; k++) step();
    check("pre_rst_cnt", cnt, 5);
    #1 reset = 1'b0;
    #1;
    check("async_rst_cnt", cnt, 0); check("async_rst_clink", clink, 0);
    step();
    check("rst_hold_cnt", cnt, 0); check("rst_hold_met", met, 0);
    reset = 1'b1; v = 1'b0;
    step();
    check("rel_cnt", cnt, 0);
    v = 1'b1;
    step();
    check("rel_hunt_cnt", cnt, 1); check("rel_hunt_met", met, 0); check("rel_hunt_clink", clink, 1);

    // randomized run against the reference model
    for (int i = 0; i < 3000; i++) begin
      rc = ($urandom_range(0, 39) != 0);
      if ($urandom_range(0, 29) == 0) sub = 4'($urandom_range(0, 11));
      if ($urandom_range(0, 19) == 0) cc = 5'($urandom_range(0, 6));
      v = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 1) t = 3'($urandom_range(1, 2));
      else t = 3'($urandom_range(0, 5));
      case ($urandom_range(0, 2))
        0: link = 8'hF7;
        1: link = 8'h01;
        default: link = 8'h02;
      endcase
      case ($urandom_range(0, 2))
        0: lane = 8'hF7;
        1: lane = 8'h01;
        default: lane = 8'h02;
      endcase
      step();
      check($sformatf("rnd%0d_met", i), met, m_met);
      check($sformatf("rnd%0d_cnt", i), cnt, m_cnt);
      check($sformatf("rnd%0d_clink", i), clink, m_clink);
      check($sformatf("rnd%0d_clane", i), clane, m_clane);
`ifdef OS_CHECKER_ERRCNT_EN
      check($sformatf("rnd%0d_err", i), err, m_err);
`endif
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
